// File: rtl/riscv_core_pkg.sv
//------------------------------------------------------------------------------
// Module   : riscv_core_pkg
// Purpose  : Shared types and constants for the RV32 core front end.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package riscv_core_pkg;

   localparam int XLEN = 32;

   localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
   localparam logic [XLEN-1:0] INSTR_NOP        = 32'h0000_0013;

   // One buffered fetch result: instruction word plus the PC it came from
   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//------------------------------------------------------------------------------
// Module   : fetch_fifo
// Purpose  : Small in-order FIFO with synchronous flush. Flush wins over any
//            same-cycle push or pop. A push into a full FIFO is accepted only
//            when a pop happens in the same cycle.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_fifo #(
   parameter int DEPTH = 2,
   parameter int WIDTH = 32
)(
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         i_flush,
   input  logic                         i_push,
   input  logic [WIDTH-1:0]             i_din,
   input  logic                         i_pop,
   output logic [WIDTH-1:0]             o_dout,
   output logic                         o_full,
   output logic                         o_empty,
   output logic [$clog2(DEPTH+1)-1:0]   o_count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] c_last = PW'(DEPTH - 1);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr_ptr;
   logic [PW-1:0]    r_rd_ptr;
   logic [CW-1:0]    r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CW'(DEPTH));
   assign o_count   = r_count;
   assign o_dout    = r_mem[r_rd_ptr];

   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && (!o_full || w_do_pop);

   // Pointer and occupancy tracking; flush returns to the empty state
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (i_flush) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= (r_wr_ptr == c_last) ? '0 : r_wr_ptr + PW'(1);
         if (w_do_pop)  r_rd_ptr <= (r_rd_ptr == c_last) ? '0 : r_rd_ptr + PW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage array; contents need no reset since occupancy gates visibility
   always_ff @(posedge clk) begin
      if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_din;
   end

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : instr_fetch_unit
// Purpose  : RV32 fetch stage. Owns the PC, issues credit-limited word
//            requests to imem, tags each in-flight request with its PC,
//            buffers responses and hands {instr, pc, pc+4} to decode.
//            A redirect flushes buffered state and drops stale responses.
// Options  : FETCH_BYPASS_EN - forward a response straight to decode when
//            the instruction FIFO is empty (zero-bubble latency).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit
   import riscv_core_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int              DEPTH    = 2
)(
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_instr,
   output logic [XLEN-1:0] id_pc,
   output logic [XLEN-1:0] id_pc_plus4
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam logic [CW:0] c_credit_max = (CW+1)'(DEPTH);

   logic [XLEN-1:0] r_pc;
   logic [CW-1:0]   r_drop_cnt;

   logic [XLEN-1:0] w_tag_pc;
   logic [CW-1:0]   w_tag_count;
   logic            w_tag_full;
   logic            w_tag_empty;
   logic            w_tag_push;

   fetch_entry_t    w_head;
   fetch_entry_t    w_push_entry;
   logic            w_fifo_full;
   logic            w_fifo_empty;
   logic [CW-1:0]   w_fifo_count;
   logic            w_fifo_push;
   logic            w_fifo_pop;

   logic [CW:0]     w_outstanding;
   logic [CW:0]     w_outstanding_next;
   logic [CW:0]     w_credit_used;
   logic            w_req_fire;
   logic            w_rsp_keep;
   logic            w_unused_bits;

   // Outstanding = requests still tagged plus requests already doomed to drop
   assign w_outstanding      = {1'b0, w_tag_count} + {1'b0, r_drop_cnt};
   assign w_credit_used      = w_outstanding + {1'b0, w_fifo_count};
   assign w_outstanding_next = w_outstanding + (CW+1)'(w_req_fire) - (CW+1)'(imem_rsp_valid);

   assign imem_req_valid = !rst && (w_credit_used < c_credit_max);
   assign imem_req_addr  = r_pc;
   assign w_req_fire     = imem_req_valid && imem_req_ready;

   // A response survives only when nothing is pending drop and no redirect
   assign w_rsp_keep   = imem_rsp_valid && (r_drop_cnt == '0) && !redirect_valid;
   assign w_tag_push   = w_req_fire && !redirect_valid;
   assign w_push_entry = '{instr: imem_rsp_data, pc: w_tag_pc};
   assign w_fifo_pop   = !w_fifo_empty && id_ready && !redirect_valid;

   assign w_unused_bits = ^{redirect_pc[1:0], w_outstanding_next[CW]};

`ifdef FETCH_BYPASS_EN
   logic w_bypass;
   assign w_bypass    = w_rsp_keep && w_fifo_empty;
   assign w_fifo_push = w_rsp_keep && !(w_bypass && id_ready);
   assign id_valid    = !w_fifo_empty || w_bypass;
   assign id_instr    = w_bypass ? imem_rsp_data : (w_fifo_empty ? '0 : w_head.instr);
   assign id_pc       = w_bypass ? w_tag_pc      : (w_fifo_empty ? '0 : w_head.pc);
`else
   assign w_fifo_push = w_rsp_keep;
   assign id_valid    = !w_fifo_empty;
   assign id_instr    = w_fifo_empty ? '0 : w_head.instr;
   assign id_pc       = w_fifo_empty ? '0 : w_head.pc;
`endif

   assign id_pc_plus4 = id_valid ? id_pc + XLEN'(4) : '0;

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (XLEN)
   ) u_tag_q (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (w_tag_push),
      .i_din   (r_pc),
      .i_pop   (w_rsp_keep),
      .o_dout  (w_tag_pc),
      .o_full  (w_tag_full),
      .o_empty (w_tag_empty),
      .o_count (w_tag_count)
   );

   fetch_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(fetch_entry_t))
   ) u_instr_q (
      .clk     (clk),
      .rst     (rst),
      .i_flush (redirect_valid),
      .i_push  (w_fifo_push),
      .i_din   (w_push_entry),
      .i_pop   (w_fifo_pop),
      .o_dout  (w_head),
      .o_full  (w_fifo_full),
      .o_empty (w_fifo_empty),
      .o_count (w_fifo_count)
   );

   // PC advance and stale-response drop counter; redirect overrides everything
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pc       <= {RESET_PC[XLEN-1:2], 2'b00};
         r_drop_cnt <= '0;
      end else if (redirect_valid) begin
         r_pc       <= {redirect_pc[XLEN-1:2], 2'b00};
         r_drop_cnt <= w_outstanding_next[CW-1:0];
      end else begin
         if (w_req_fire) r_pc <= r_pc + XLEN'(4);
         if (imem_rsp_valid && (r_drop_cnt != '0)) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
   end

`ifndef SYNTHESIS
   a_credit_limit: assert property (@(posedge clk) disable iff (rst)
      w_credit_used <= c_credit_max);
   a_fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_fifo_push && w_fifo_full && !w_fifo_pop && !redirect_valid));
   a_tag_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_tag_push && w_tag_full));
   a_tag_no_underflow: assert property (@(posedge clk) disable iff (rst)
      !(w_rsp_keep && w_tag_empty));
`endif

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit (DEPTH = 2)
//            with a fixed-latency in-order instruction memory model.
//            Honours FETCH_BYPASS_EN for the latency-sensitive steps.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

   logic        clk;
   logic        rst;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_instr;
   logic [31:0] id_pc;
   logic [31:0] id_pc_plus4;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int lat      = 1;
   int accepts  = 0;

   logic [31:0] q_addr [$];
   int          q_due  [$];

   instr_fetch_unit #(
      .RESET_PC (32'h0000_0000),
      .DEPTH    (2)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_instr       (id_instr),
      .id_pc          (id_pc),
      .id_pc_plus4    (id_pc_plus4)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: a simple address-derived pattern
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0013;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: log an accepted request, then present any response now due
   task automatic tick();
      logic        acc;
      logic [31:0] a;
      acc = imem_req_valid && imem_req_ready;
      a   = imem_req_addr;
      @(posedge clk);
      #1;
      if (acc) begin
         q_addr.push_back(a);
         q_due.push_back(cyc + lat);
         accepts++;
      end
      cyc++;
      if (q_due.size() > 0 && q_due[0] == cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(q_addr[0]);
         void'(q_addr.pop_front());
         void'(q_due.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = '0;
      end
      #1;
   endtask

   task automatic do_reset();
      rst            = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      q_addr.delete();
      q_due.delete();
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      cyc     = 0;
      accepts = 0;
      #1;
   endtask

   task automatic wait_id(input string tag, input int max);
      int n = 0;
      while (!id_valid && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_id_timeout"}, id_valid, 1);
   endtask

   task automatic wait_req(input string tag, input int max);
      int n = 0;
      while (!imem_req_valid && n < max) begin
         tick();
         n++;
      end
      chk({tag, "_req_timeout"}, imem_req_valid, 1);
   endtask

   initial begin
      rst            = 1'b1;
      imem_req_ready = 1'b1;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      id_ready       = 1'b1;
      #3;
      chk("rst_req_valid", imem_req_valid, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_id_instr", id_instr, 0);
      chk("rst_id_pc", id_pc, 0);
      chk("rst_id_pc_plus4", id_pc_plus4, 0);

      // Streaming, latency 1, decode always ready
      lat = 1;
      do_reset();
      chk("t1_c0_req_valid", imem_req_valid, 1);
      chk("t1_c0_addr", imem_req_addr, 32'h0000_0000);
      tick();
      chk("t1_c1_addr", imem_req_addr, 32'h0000_0004);
`ifdef FETCH_BYPASS_EN
      chk("t1_c1_byp_valid", id_valid, 1);
      chk("t1_c1_byp_pc", id_pc, 32'h0000_0000);
      chk("t1_c1_byp_instr", id_instr, 32'h5A5A_0013);
      tick();
`else
      chk("t1_c1_id_valid", id_valid, 0);
      tick();
      chk("t1_c2_id_valid", id_valid, 1);
      chk("t1_c2_id_pc", id_pc, 32'h0000_0000);
      chk("t1_c2_pc_plus4", id_pc_plus4, 32'h0000_0004);
      chk("t1_c2_instr", id_instr, 32'h5A5A_0013);
      chk("t1_c2_req_credit", imem_req_valid, 0);
      tick();
      chk("t1_c3_id_pc", id_pc, 32'h0000_0004);
      chk("t1_c3_instr", id_instr, 32'h5A5A_0017);
      chk("t1_c3_req_valid", imem_req_valid, 1);
      chk("t1_c3_addr", imem_req_addr, 32'h0000_0008);
      tick();
      chk("t1_c4_id_valid", id_valid, 0);
      tick();
      chk("t1_c5_id_pc", id_pc, 32'h0000_0008);
      chk("t1_c5_pc_plus4", id_pc_plus4, 32'h0000_000C);
`endif

      // Decode stalled for 10 cycles: credit limit caps requests at two
      lat      = 1;
      id_ready = 1'b0;
      do_reset();
      repeat (10) tick();
      chk("t2_accepts", 32'(accepts), 2);
      chk("t2_req_valid", imem_req_valid, 0);
      chk("t2_id_valid", id_valid, 1);
      chk("t2_head_pc", id_pc, 32'h0000_0000);
      chk("t2_head_instr", id_instr, 32'h5A5A_0013);
      id_ready = 1'b1;
      tick();
      chk("t2_second_pc", id_pc, 32'h0000_0004);
      chk("t2_resume_valid", imem_req_valid, 1);
      chk("t2_resume_addr", imem_req_addr, 32'h0000_0008);
      tick();
      wait_id("t2_third", 10);
      chk("t2_third_pc", id_pc, 32'h0000_0008);
      tick();

      // Latency 3, redirect with two requests in flight
      lat = 3;
      do_reset();
      tick();
      tick();
      chk("t3_two_inflight", imem_req_valid, 0);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      chk("t3_post_redirect_id", id_valid, 0);
      wait_req("t3_req", 10);
      chk("t3_req_addr", imem_req_addr, 32'h0000_0100);
      wait_id("t3_first", 20);
      chk("t3_first_pc", id_pc, 32'h0000_0100);
      chk("t3_first_instr", id_instr, 32'h5A5A_0113);
      tick();
      wait_id("t3_second", 20);
      chk("t3_second_pc", id_pc, 32'h0000_0104);
      tick();

      // Redirect coinciding with a request accept and a response arrival
      lat = 1;
      do_reset();
      tick();
      chk("t4_c1_req_valid", imem_req_valid, 1);
      chk("t4_c1_rsp_present", imem_rsp_valid, 1);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0100;
      tick();
      redirect_valid = 1'b0;
      chk("t4_post_redirect_id", id_valid, 0);
      chk("t4_req_addr", imem_req_addr, 32'h0000_0100);
      wait_id("t4_a", 10);
      chk("t4_pc_a", id_pc, 32'h0000_0100);
      tick();
      wait_id("t4_b", 10);
      chk("t4_pc_b", id_pc, 32'h0000_0104);
      tick();
      wait_id("t4_c", 10);
      chk("t4_pc_c", id_pc, 32'h0000_0108);
      chk("t4_instr_c", id_instr, 32'h5A5A_011B);
      tick();

      // Address wrap at the top of memory, then unaligned redirect target
      lat = 1;
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      tick();
      redirect_valid = 1'b0;
      chk("t5_top_addr", imem_req_addr, 32'hFFFF_FFFC);
      tick();
      chk("t5_wrap_addr", imem_req_addr, 32'h0000_0000);
      wait_id("t5_top", 10);
      chk("t5_top_pc", id_pc, 32'hFFFF_FFFC);
      chk("t5_top_plus4", id_pc_plus4, 32'h0000_0000);
      chk("t5_top_instr", id_instr, 32'hA5A5_FFEF);
      tick();
      wait_id("t5_wrap", 10);
      chk("t5_wrap_pc", id_pc, 32'h0000_0000);
      chk("t5_wrap_plus4", id_pc_plus4, 32'h0000_0004);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_0203;
      tick();
      redirect_valid = 1'b0;
      wait_req("t5_align", 10);
      chk("t5_align_addr", imem_req_addr, 32'h0000_0200);
      wait_id("t5_align", 20);
      chk("t5_align_pc", id_pc, 32'h0000_0200);
      chk("t5_align_instr", id_instr, 32'h5A5A_0213);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire
